// File: rtl/vram_ddr_responder_pkg.sv
// Shared types and constants for the PVR VRAM to DDR3 Avalon responder.
package vram_ddr_responder_pkg;

  localparam int VRAM_WORD_MSB = 22;
  localparam int DDR_ADDR_W    = 29;
  localparam int DATA_W        = 64;

  localparam logic [DATA_W-1:0] ERR_PATTERN = 64'hDEADBEEF_DEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_DRAIN = 2'd1,
    ST_RD_ISSUE = 2'd2,
    ST_RD_WAIT  = 2'd3
  } rd_state_e;

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wentry_t;

  // Byte address to DDR word address; the add wraps modulo 2^29.
  function automatic logic [DDR_ADDR_W-1:0] map_addr(input logic [DDR_ADDR_W-1:0] base,
                                                     input logic [23:0]            byte_addr);
    return base + DDR_ADDR_W'(byte_addr[VRAM_WORD_MSB:3]);
  endfunction

endpackage

// File: rtl/vram_ddr_responder_wfifo.sv
// Posted-write FIFO: synchronous, power-of-two depth, first-word-fall-through head.
module vram_ddr_responder_wfifo
  import vram_ddr_responder_pkg::*;
#(
  parameter int WFIFO_DEPTH = 4
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    push,
  input  wentry_t push_data,
  input  logic    pop,
  output wentry_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);

  wentry_t          mem [WFIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/vram_ddr_responder.sv
// PVR VRAM port responder: posted writes through a FIFO, reads serialised behind them
// onto a window of the shared DDR3 Avalon-MM master port.
module vram_ddr_responder
  import vram_ddr_responder_pkg::*;
#(
  parameter logic [28:0] DDR_BASE    = 29'h0100000,
  parameter int          WFIFO_DEPTH = 4,
  parameter int          RD_TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        vram_rd,
  input  logic        vram_wr,
  input  logic [23:0] vram_addr,
  input  logic [63:0] vram_wdata,
  output logic        vram_wait,
  output logic        vram_valid,
  output logic [63:0] vram_din,
  output logic [28:0] ddr_addr,
  output logic        ddr_rd,
  output logic        ddr_wr,
  output logic [63:0] ddr_wdata,
  output logic [7:0]  ddr_burstcnt,
  input  logic        ddr_waitrequest,
  input  logic [63:0] ddr_rdata,
  input  logic        ddr_rdata_valid,
  output logic        rd_timeout_err
);

  localparam int               TMR_W     = $clog2(RD_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(RD_TIMEOUT);

  rd_state_e        state;
  logic [28:0]      rd_addr;
  logic [TMR_W-1:0] timer;
  logic [1:0]       stale;

  wentry_t head;
  wentry_t push_entry;
  logic    full;
  logic    empty;
  logic    wr_acc;
  logic    rd_acc;
  logic    pop;
  logic    rsp_take;
  logic    rsp_timeout;
  logic    unused_addr_bits;

  // Stale-response counter update, saturating at 3.
  function automatic logic [1:0] next_stale(input logic [1:0] cur,
                                            input logic       dec,
                                            input logic       inc);
    logic [2:0] t;
    t = {1'b0, cur};
    if (dec && (cur != 2'd0)) t = t - 3'd1;
    if (inc)                  t = t + 3'd1;
    return (t > 3'd3) ? 2'd3 : t[1:0];
  endfunction

  assign unused_addr_bits = ^{vram_addr[23], vram_addr[2:0]};

  // Stall depends only on registered state so the PVR side sees no combinational loop.
  assign vram_wait = full | (state != ST_IDLE);
  assign wr_acc    = vram_wr & ~vram_wait;
  assign rd_acc    = vram_rd & ~vram_wr & ~vram_wait;

  assign push_entry = '{addr: map_addr(DDR_BASE, vram_addr), data: vram_wdata};

  assign ddr_rd       = (state == ST_RD_ISSUE);
  assign ddr_wr       = ~empty & (state != ST_RD_ISSUE);
  assign pop          = ddr_wr & ~ddr_waitrequest;
  assign ddr_addr     = ddr_rd ? rd_addr : (ddr_wr ? head.addr : '0);
  assign ddr_wdata    = ddr_wr ? head.data : '0;
  assign ddr_burstcnt = 8'd1;

  assign rsp_take    = (state == ST_RD_WAIT) & ddr_rdata_valid & (stale == 2'd0);
  assign rsp_timeout = (state == ST_RD_WAIT) & ~rsp_take & (timer == TMR_LIMIT);

  vram_ddr_responder_wfifo #(
    .WFIFO_DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (wr_acc),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock) begin
    if (state == ST_IDLE && rd_acc) rd_addr <= map_addr(DDR_BASE, vram_addr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      timer          <= '0;
      stale          <= 2'd0;
      vram_valid     <= 1'b0;
      vram_din       <= '0;
      rd_timeout_err <= 1'b0;
    end else begin
      vram_valid <= 1'b0;
      stale      <= next_stale(stale, ddr_rdata_valid, rsp_timeout);
      case (state)
        ST_IDLE: begin
          if (rd_acc) state <= empty ? ST_RD_ISSUE : ST_RD_DRAIN;
        end
        ST_RD_DRAIN: begin
          if (empty) state <= ST_RD_ISSUE;
        end
        ST_RD_ISSUE: begin
          if (!ddr_waitrequest) begin
            state <= ST_RD_WAIT;
            timer <= '0;
          end
        end
        ST_RD_WAIT: begin
          if (rsp_take) begin
            vram_din   <= ddr_rdata;
            vram_valid <= 1'b1;
            state      <= ST_IDLE;
          end else if (rsp_timeout) begin
            vram_din       <= ERR_PATTERN;
            vram_valid     <= 1'b1;
            rd_timeout_err <= 1'b1;
            state          <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_ddr_responder.sv
// Bench for vram_ddr_responder: DDR memory model, shadow VRAM scoreboard, directed and random traffic.
module tb_vram_ddr_responder;

  localparam logic [28:0] BASE = 29'h0100000;
  localparam int          TMO  = 255;
  localparam logic [63:0] ERRW = 64'hDEADBEEF_DEADBEEF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        vram_rd = 1'b0;
  logic        vram_wr = 1'b0;
  logic [23:0] vram_addr = '0;
  logic [63:0] vram_wdata = '0;
  logic        vram_wait;
  logic        vram_valid;
  logic [63:0] vram_din;
  logic [28:0] ddr_addr;
  logic        ddr_rd;
  logic        ddr_wr;
  logic [63:0] ddr_wdata;
  logic [7:0]  ddr_burstcnt;
  logic        ddr_waitrequest = 1'b0;
  logic [63:0] ddr_rdata = '0;
  logic        ddr_rdata_valid = 1'b0;
  logic        rd_timeout_err;

  always #5 clock = ~clock;

  vram_ddr_responder dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .vram_rd         (vram_rd),
    .vram_wr         (vram_wr),
    .vram_addr       (vram_addr),
    .vram_wdata      (vram_wdata),
    .vram_wait       (vram_wait),
    .vram_valid      (vram_valid),
    .vram_din        (vram_din),
    .ddr_addr        (ddr_addr),
    .ddr_rd          (ddr_rd),
    .ddr_wr          (ddr_wr),
    .ddr_wdata       (ddr_wdata),
    .ddr_burstcnt    (ddr_burstcnt),
    .ddr_waitrequest (ddr_waitrequest),
    .ddr_rdata       (ddr_rdata),
    .ddr_rdata_valid (ddr_rdata_valid),
    .rd_timeout_err  (rd_timeout_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: VRAM contents as the PVR sees them, and DDR memory contents.
  typedef struct { logic [28:0] a; logic [63:0] d; } wexp_t;
  typedef struct { int due; logic [63:0] d; } rsp_t;

  logic [63:0] shadow [logic [19:0]];
  logic [63:0] mem    [logic [28:0]];
  wexp_t       exp_w  [$];
  logic [63:0] exp_r  [$];
  rsp_t        resp_q [$];

  int cyc = 0;
  int wait_pct = 0;
  int lat_max = 0;
  int lat_extra = 0;
  bit force_wait = 0;
  bit drop_rd = 0;
  bit inject = 0;
  int rd_hs = 0;
  int valid_cnt = 0;
  int proto_viol = 0;
  int last_wr_cyc = 0;
  int last_rd_cyc = 0;
  bit prev_valid = 0;

  function automatic logic [63:0] init_word(input logic [28:0] a);
    return {a[15:0], ~a[15:0], a[28:13], a[15:0] ^ 16'h5A3C};
  endfunction

  function automatic logic [63:0] vram_expect(input logic [19:0] idx);
    if (shadow.exists(idx)) return shadow[idx];
    return init_word(BASE + 29'(idx));
  endfunction

  always @(posedge clock) begin
    if (reset_n && vram_rd && vram_wr) begin
      proto_viol++;
      $display("protocol violation: vram_rd and vram_wr together at %0t", $time);
    end
  end

  always @(negedge clock) begin : mon
    wexp_t       w;
    rsp_t        r;
    logic [63:0] e;
    logic [19:0] idx;
    cyc++;
    if (!reset_n) begin
      exp_w.delete();
      exp_r.delete();
      ddr_waitrequest = 1'b0;
      ddr_rdata_valid = 1'b0;
      prev_valid      = 1'b0;
    end else begin
      if (vram_valid) begin
        valid_cnt++;
        chk("valid_one_cycle", 64'(prev_valid), 64'd0);
        if (exp_r.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
        else begin
          e = exp_r.pop_front();
          chk("read_data", vram_din, e);
        end
      end
      prev_valid = vram_valid;

      idx = vram_addr[22:3];
      if (vram_wr && !vram_wait) begin
        w.a = BASE + 29'(idx);
        w.d = vram_wdata;
        exp_w.push_back(w);
        shadow[idx] = vram_wdata;
      end else if (vram_rd && !vram_wait) begin
        exp_r.push_back(drop_rd ? ERRW : vram_expect(idx));
      end

      ddr_waitrequest = force_wait || (int'($urandom_range(99)) < wait_pct);
      ddr_rdata_valid = 1'b0;
      ddr_rdata       = {$urandom, $urandom};
      if (inject) begin
        ddr_rdata_valid = 1'b1;
        ddr_rdata       = 64'hBAD0BAD0_BAD0BAD0;
        inject          = 1'b0;
      end else if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
        r = resp_q.pop_front();
        ddr_rdata_valid = 1'b1;
        ddr_rdata       = r.d;
      end

      if (ddr_wr && !ddr_waitrequest) begin
        last_wr_cyc = cyc;
        if (exp_w.size() == 0) chk("spurious_ddr_wr", 64'd1, 64'd0);
        else begin
          w = exp_w.pop_front();
          chk("ddr_wr_addr", 64'(ddr_addr), 64'(w.a));
          chk("ddr_wr_data", ddr_wdata, w.d);
        end
        mem[ddr_addr] = ddr_wdata;
      end
      if (ddr_rd && !ddr_waitrequest) begin
        rd_hs++;
        last_rd_cyc = cyc;
        chk("rd_after_writes", 64'(exp_w.size()), 64'd0);
        chk("rd_wr_exclusive", 64'(ddr_wr), 64'd0);
        if (!drop_rd) begin
          r.due = cyc + 1 + lat_extra + int'($urandom_range(lat_max));
          r.d   = mem.exists(ddr_addr) ? mem[ddr_addr] : init_word(ddr_addr);
          resp_q.push_back(r);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clock);
    #2;
  endtask

  // Called at posedge+2; returns at posedge+2 after the accepting edge, inputs idle.
  task automatic do_req(input bit rd, input bit wr, input logic [23:0] a, input logic [63:0] d);
    bit ok;
    ok = 0;
    vram_rd = rd; vram_wr = wr; vram_addr = a; vram_wdata = d;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (!vram_wait) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd1, 64'd0);
    sync();
    vram_rd = 1'b0; vram_wr = 1'b0;
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (exp_w.size() == 0 && exp_r.size() == 0 && !vram_wait && !ddr_wr) begin ok = 1; break; end
    end
    if (!ok) chk("quiet_timeout", 64'd1, 64'd0);
    sync();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wait"},   64'(vram_wait), 64'd0);
    chk({tag, "_valid"},  64'(vram_valid), 64'd0);
    chk({tag, "_din"},    vram_din, 64'd0);
    chk({tag, "_ddr_rd"}, 64'(ddr_rd), 64'd0);
    chk({tag, "_ddr_wr"}, 64'(ddr_wr), 64'd0);
    chk({tag, "_addr"},   64'(ddr_addr), 64'd0);
    chk({tag, "_wdata"},  ddr_wdata, 64'd0);
    chk({tag, "_burst"},  64'(ddr_burstcnt), 64'd1);
    chk({tag, "_tmo"},    64'(rd_timeout_err), 64'd0);
  endtask

  initial begin
    int n;
    int v0;
    int h0;
    bit ok;
    logic [19:0] ridx;
    logic [23:0] ra;

    #1;
    chk_zero_outputs("reset");
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    sync();

    // 1: single write, no stall
    do_req(0, 1, 24'h000008, 64'h1122334455667788);
    @(negedge clock);
    chk("t1_ddr_wr", 64'(ddr_wr), 64'd1);
    chk("t1_ddr_addr", 64'(ddr_addr), 64'h0100001);
    chk("t1_ddr_wdata", ddr_wdata, 64'h1122334455667788);
    sync();
    wait_quiet();

    // read latency with empty FIFO and no stall
    do_req(1, 0, 24'h000008, 64'd0);
    @(negedge clock);
    chk("lat_ddr_rd", 64'(ddr_rd), 64'd1);
    chk("lat_ddr_addr", 64'(ddr_addr), 64'h0100001);
    @(negedge clock);
    chk("lat_valid_early", 64'(vram_valid), 64'd0);
    @(negedge clock);
    chk("lat_valid", 64'(vram_valid), 64'd1);
    @(negedge clock);
    chk("lat_valid_drop", 64'(vram_valid), 64'd0);
    sync();
    wait_quiet();

    // 2: back-to-back writes into a stalled DDR port
    force_wait = 1;
    for (int i = 0; i < 4; i++) do_req(0, 1, 24'(32'h100 + i * 8), 64'hA000_0000_0000_0000 + 64'(i));
    @(negedge clock);
    chk("t2_full_wait", 64'(vram_wait), 64'd1);
    sync();
    vram_wr = 1'b1; vram_addr = 24'h000120; vram_wdata = 64'hA000_0000_0000_0004;
    repeat (3) @(negedge clock);
    chk("t2_still_wait", 64'(vram_wait), 64'd1);
    chk("t2_head_addr", 64'(ddr_addr), 64'(BASE + 29'h20));
    sync();
    force_wait = 0;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (!vram_wait) begin ok = 1; break; end
    end
    chk("t2_fifth_accept", 64'(ok), 64'd1);
    sync();
    vram_wr = 1'b0;
    wait_quiet();
    chk("t2_wait_dropped", 64'(vram_wait), 64'd0);

    // 3: write then immediate read of the same word
    wait_pct = 50;
    do_req(0, 1, 24'h000010, 64'hCAFEF00D_12345678);
    do_req(1, 0, 24'h000010, 64'd0);
    wait_quiet();
    chk("t3_rd_after_wr", 64'(last_rd_cyc > last_wr_cyc), 64'd1);
    wait_pct = 0;

    // 4: DDR never answers, then the late answer must be discarded
    drop_rd = 1;
    do_req(1, 0, 24'h000010, 64'd0);
    n = 0;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      n++;
      if (vram_valid) begin ok = 1; break; end
    end
    chk("t4_timeout_seen", 64'(ok), 64'd1);
    chk("t4_timeout_window", 64'(n >= TMO && n <= TMO + 10), 64'd1);
    chk("t4_err_flag", 64'(rd_timeout_err), 64'd1);
    sync();
    drop_rd = 0;
    lat_extra = 3;
    do_req(1, 0, 24'h000010, 64'd0);
    sync();
    inject = 1;
    wait_quiet();
    lat_extra = 0;
    chk("t4_err_sticky", 64'(rd_timeout_err), 64'd1);

    // 5: reset while a read waits on DDR, stray data afterwards
    lat_extra = 30;
    do_req(1, 0, 24'h000008, 64'd0);
    repeat (5) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk_zero_outputs("t5");
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    lat_extra = 0;
    v0 = valid_cnt;
    repeat (40) @(negedge clock);
    chk("t5_stray_delivered", 64'(resp_q.size()), 64'd0);
    chk("t5_no_valid", 64'(valid_cnt), 64'(v0));
    sync();

    // 6: simultaneous read and write request
    v0 = proto_viol;
    h0 = rd_hs;
    do_req(1, 1, 24'h000200, 64'h0123456789ABCDEF);
    wait_quiet();
    chk("t6_violation_flagged", 64'(proto_viol - v0), 64'd1);
    chk("t6_no_ddr_rd", 64'(rd_hs), 64'(h0));
    do_req(1, 0, 24'h000200, 64'd0);
    wait_quiet();

    // random traffic against the shadow memory
    wait_pct = 25;
    lat_max = 3;
    for (int i = 0; i < 300; i++) begin
      ridx = ($urandom_range(9) == 0) ? 20'($urandom) : 20'($urandom_range(15));
      ra   = {1'($urandom), ridx, 3'($urandom)};
      if ($urandom_range(1) == 0) do_req(0, 1, ra, {$urandom, $urandom});
      else                        do_req(1, 0, ra, 64'd0);
      if ($urandom_range(3) == 0) sync();
    end
    wait_quiet();
    chk("final_rd_pending", 64'(exp_r.size()), 64'd0);
    chk("final_wr_pending", 64'(exp_w.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
